// File: rtl/motor_pkg.sv
// Shared types and widths for the motor segment queue.
//   SEG_W / DIV_W / STEPS_W : segment field widths
//   motor_seg_t             : packed segment {dir, divider, steps}
//   POS_W_DEFAULT           : default width of the signed position accumulator
package motor_pkg;

    localparam int unsigned SEG_W         = 31;
    localparam int unsigned DIV_W         = 15;
    localparam int unsigned STEPS_W       = 15;
    localparam int unsigned POS_W_DEFAULT = 19;

    typedef struct packed {
        logic               dir;
        logic [DIV_W-1:0]   divider;
        logic [STEPS_W-1:0] steps;
    } motor_seg_t;

endpackage

// File: rtl/motor_seg_fifo.sv
// Synchronous circular FIFO of motor segments with a registered head.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   push_i, push_seg_i : enqueue request and data (dropped when full without a pop)
//   pop_i              : dequeue request (ignored when empty)
//   flush_i            : discard everything; push/pop in the same cycle are ignored
//   head_o, head_valid_o : registered head entry, valid one cycle after it reaches the head
//   level_o, full_o    : entries held, level_o == DEPTH
module motor_seg_fifo
    import motor_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  motor_seg_t               push_seg_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output motor_seg_t               head_o,
    output logic                     head_valid_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    motor_seg_t         mem_q [DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    motor_seg_t         head_q;
    logic               head_valid_q;
    logic [PTR_W:0]     level;
    logic               empty;
    logic               do_push;
    logic               do_pop;

    // Extra pointer bit makes the difference equal the fill level directly.
    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = (level == '0);
    assign full_o  = (level == (PTR_W + 1)'(DEPTH));
    assign level_o = level;

    assign do_pop  = pop_i && !empty && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: every slot is written before the head can expose it.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_seg_i;
    end

    // Head follows the committed read pointer one cycle later, so a pop is only
    // reflected after the following edge.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            head_q       <= mem_q[rd_ptr_q[PTR_W-1:0]];
            head_valid_q <= !empty;
        end
    end

    assign head_o       = head_q;
    assign head_valid_o = head_valid_q;

endmodule

// File: rtl/motor_seg_queue.sv
// Segment feeder and position tracker for the single-axis step generator.
//   CLK, reset                         : clock, synchronous active-high reset
//   wr_en, wr_dir, wr_divider, wr_steps: segment write from the host parser
//   flush                              : discard all queued segments, clear overflow
//   seg_take                           : generator latched the head this cycle
//   stepsToGo, divider, dirInput       : head segment, zero when empty
//   seg_valid, full, level, overflow   : queue status (overflow is sticky)
//   step, dir                          : generator outputs, tracked for position
//   pos_clear                          : zero the position (wins over a same-cycle edge)
//   cur_position                       : signed absolute step position, wraps at POS_W
module motor_seg_queue
    import motor_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned POS_W = POS_W_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic                     wr_dir,
    input  logic [DIV_W-1:0]         wr_divider,
    input  logic [STEPS_W-1:0]       wr_steps,
    input  logic                     flush,
    input  logic                     seg_take,
    output logic [STEPS_W-1:0]       stepsToGo,
    output logic [DIV_W-1:0]         divider,
    output logic                     dirInput,
    output logic                     seg_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     step,
    input  logic                     dir,
    input  logic                     pos_clear,
    output logic signed [POS_W-1:0]  cur_position
);

    motor_seg_t head;
    motor_seg_t wr_seg;
    logic       head_valid;
    logic       wr_req;
    logic       pop;
    logic       push;
    logic       overflow_q, overflow_d;

    // Zero-step segments are no-ops and never occupy a slot.
    assign wr_req = wr_en && (wr_steps != '0);
    assign pop    = seg_take && head_valid;
    assign push   = wr_req && (!full || pop);

    assign wr_seg = '{dir: wr_dir, divider: wr_divider, steps: wr_steps};

    motor_seg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (CLK),
        .rst_i        (reset),
        .push_i       (push),
        .push_seg_i   (wr_seg),
        .pop_i        (pop),
        .flush_i      (flush),
        .head_o       (head),
        .head_valid_o (head_valid),
        .level_o      (level),
        .full_o       (full)
    );

    always_comb begin
        overflow_d = overflow_q;
        if (flush) begin
            overflow_d = 1'b0;
        end else if (wr_req && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

    assign overflow  = overflow_q;
    assign seg_valid = head_valid;

    // An idle generator must see stepsToGo == 0, so stale storage never leaks out.
    assign stepsToGo = head_valid ? head.steps   : '0;
    assign divider   = head_valid ? head.divider : '0;
    assign dirInput  = head_valid ? head.dir     : 1'b0;

    // Position tracker: step/dir are sampled once, then the edge is taken between
    // the sampled value and its predecessor.
    logic                    step_q;
    logic                    step_prev_q;
    logic                    dir_q;
    logic                    step_edge;
    logic signed [POS_W-1:0] pos_q, pos_d;

    localparam logic signed [POS_W-1:0] PosOne = POS_W'(1);

    assign step_edge = step_q && !step_prev_q;

    always_comb begin
        pos_d = pos_q;
        if (pos_clear) begin
            pos_d = '0;
        end else if (step_edge) begin
            pos_d = dir_q ? (pos_q + PosOne) : (pos_q - PosOne);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            step_q      <= 1'b0;
            step_prev_q <= 1'b0;
            dir_q       <= 1'b0;
            pos_q       <= '0;
        end else begin
            step_q      <= step;
            step_prev_q <= step_q;
            dir_q       <= dir;
            pos_q       <= pos_d;
        end
    end

    assign cur_position = pos_q;

endmodule

// File: tb/tb_motor_seg_queue.sv
module tb_motor_seg_queue;

    logic               CLK;
    logic               reset;
    logic               wr_en;
    logic               wr_dir;
    logic [14:0]        wr_divider;
    logic [14:0]        wr_steps;
    logic               flush;
    logic               seg_take;
    logic [14:0]        stepsToGo;
    logic [14:0]        divider;
    logic               dirInput;
    logic               seg_valid;
    logic               full;
    logic [2:0]         level;
    logic               overflow;
    logic               step;
    logic               dir;
    logic               pos_clear;
    logic signed [18:0] cur_position;

    int checks = 0;
    int errors = 0;

    motor_seg_queue #(
        .DEPTH (4),
        .POS_W (19)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_dir       (wr_dir),
        .wr_divider   (wr_divider),
        .wr_steps     (wr_steps),
        .flush        (flush),
        .seg_take     (seg_take),
        .stepsToGo    (stepsToGo),
        .divider      (divider),
        .dirInput     (dirInput),
        .seg_valid    (seg_valid),
        .full         (full),
        .level        (level),
        .overflow     (overflow),
        .step         (step),
        .dir          (dir),
        .pos_clear    (pos_clear),
        .cur_position (cur_position)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_wr(input logic d, input int dv, input int st);
        wr_en      = 1'b1;
        wr_dir     = d;
        wr_divider = 15'(dv);
        wr_steps   = 15'(st);
    endtask

    task automatic step_pulse(input logic d);
        dir  = d;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (seg_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", seg_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d want 0", level); end
        checks++; if (full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_flags got full=%b ovf=%b want 0 0", full, overflow); end
        checks++; if (stepsToGo !== 15'd0 || divider !== 15'd0 || dirInput !== 1'b0) begin errors++; $display("FAIL rst_head got %0d/%0d/%b want 0/0/0", stepsToGo, divider, dirInput); end
        checks++; if (cur_position !== 19'sd0) begin errors++; $display("FAIL rst_pos got %0d want 0", cur_position); end
        reset = 1'b0;
        tick();
        // Mid-operation reset: queue and position discarded together.
        drive_wr(1'b1, 10, 2);
        tick();
        wr_en = 1'b0;
        step_pulse(1'b1);
        checks++; if (cur_position !== 19'sd1 || level !== 3'd1) begin errors++; $display("FAIL pre_rst got pos=%0d lvl=%0d want 1 1", cur_position, level); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (cur_position !== 19'sd0 || level !== 3'd0) begin errors++; $display("FAIL mid_rst got pos=%0d lvl=%0d want 0 0", cur_position, level); end
        tick();
        tick();
        checks++; if (seg_valid !== 1'b0 || stepsToGo !== 15'd0) begin errors++; $display("FAIL rst_noreload got v=%b steps=%0d want 0 0", seg_valid, stepsToGo); end
    endtask

    task automatic test_write_take();
        drive_wr(1'b1, 100, 5);
        tick();
        wr_en = 1'b0;
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL wr_level got %0d want 1", level); end
        checks++; if (seg_valid !== 1'b0) begin errors++; $display("FAIL wr_latency got %b want 0", seg_valid); end
        tick();
        checks++; if (seg_valid !== 1'b1 || stepsToGo !== 15'd5 || divider !== 15'd100 || dirInput !== 1'b1) begin errors++; $display("FAIL wr_head got v=%b %0d/%0d/%b want 1 5/100/1", seg_valid, stepsToGo, divider, dirInput); end
        seg_take = 1'b1;
        tick();
        seg_take = 1'b0;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL take_level got %0d want 0", level); end
        tick();
        checks++; if (seg_valid !== 1'b0 || stepsToGo !== 15'd0 || divider !== 15'd0 || dirInput !== 1'b0) begin errors++; $display("FAIL take_head got v=%b %0d/%0d/%b want 0 0/0/0", seg_valid, stepsToGo, divider, dirInput); end
    endtask

    task automatic test_overflow_flush();
        for (int i = 1; i <= 5; i++) begin
            drive_wr(1'b0, 20 + i, i);
            tick();
            if (i == 4) begin
                checks++; if (full !== 1'b1 || level !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL fill4 got full=%b lvl=%0d ovf=%b want 1 4 0", full, level, overflow); end
            end
        end
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1 || level !== 3'd4) begin errors++; $display("FAIL ovf_set got ovf=%b lvl=%0d want 1 4", overflow, level); end
        tick();
        checks++; if (stepsToGo !== 15'd1 || divider !== 15'd21) begin errors++; $display("FAIL ovf_head got %0d/%0d want 1/21", stepsToGo, divider); end
        flush = 1'b1;
        drive_wr(1'b1, 7, 7);
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        checks++; if (level !== 3'd0 || overflow !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL flush got lvl=%0d ovf=%b full=%b want 0 0 0", level, overflow, full); end
        checks++; if (seg_valid !== 1'b0 || stepsToGo !== 15'd0) begin errors++; $display("FAIL flush_head got v=%b steps=%0d want 0 0", seg_valid, stepsToGo); end
        tick();
        checks++; if (level !== 3'd0 || seg_valid !== 1'b0) begin errors++; $display("FAIL flush_wr got lvl=%0d v=%b want 0 0", level, seg_valid); end
    endtask

    task automatic test_full_push_pop();
        int exp_steps [4] = '{2, 3, 4, 9};
        for (int i = 1; i <= 4; i++) begin
            drive_wr(1'b0, 10 + i, i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        drive_wr(1'b1, 50, 9);
        seg_take = 1'b1;
        tick();
        wr_en    = 1'b0;
        seg_take = 1'b0;
        checks++; if (level !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL pushpop got lvl=%0d ovf=%b full=%b want 4 0 1", level, overflow, full); end
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++; if (stepsToGo !== 15'(exp_steps[k]) || seg_valid !== 1'b1) begin errors++; $display("FAIL order%0d got v=%b steps=%0d want 1 %0d", k, seg_valid, stepsToGo, exp_steps[k]); end
            if (k == 3) begin
                checks++; if (divider !== 15'd50 || dirInput !== 1'b1) begin errors++; $display("FAIL order_new got %0d/%b want 50/1", divider, dirInput); end
            end
            seg_take = 1'b1;
            tick();
            seg_take = 1'b0;
            tick();
        end
        checks++; if (level !== 3'd0 || seg_valid !== 1'b0) begin errors++; $display("FAIL drain got lvl=%0d v=%b want 0 0", level, seg_valid); end
    endtask

    task automatic test_zero_and_empty();
        drive_wr(1'b1, 5, 0);
        tick();
        wr_en = 1'b0;
        tick();
        checks++; if (level !== 3'd0 || seg_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL zero_steps got lvl=%0d v=%b ovf=%b want 0 0 0", level, seg_valid, overflow); end
        seg_take = 1'b1;
        tick();
        seg_take = 1'b0;
        tick();
        checks++; if (level !== 3'd0 || seg_valid !== 1'b0 || stepsToGo !== 15'd0) begin errors++; $display("FAIL take_empty got lvl=%0d v=%b steps=%0d want 0 0 0", level, seg_valid, stepsToGo); end
    endtask

    task automatic test_position();
        pos_clear = 1'b1;
        tick();
        pos_clear = 1'b0;
        for (int i = 0; i < 7; i++) step_pulse(1'b1);
        for (int i = 0; i < 3; i++) step_pulse(1'b0);
        checks++; if (cur_position !== 19'sd4) begin errors++; $display("FAIL pos_count got %0d want 4", cur_position); end
        // Clear in the cycle the edge is detected.
        dir  = 1'b1;
        step = 1'b1;
        tick();
        pos_clear = 1'b1;
        step      = 1'b0;
        tick();
        pos_clear = 1'b0;
        checks++; if (cur_position !== 19'sd0) begin errors++; $display("FAIL pos_clear got %0d want 0", cur_position); end
        tick();
        checks++; if (cur_position !== 19'sd0) begin errors++; $display("FAIL pos_clear_hold got %0d want 0", cur_position); end
        dir  = 1'b0;
        step = 1'b1;
        tick();
        checks++; if (cur_position !== 19'sd0) begin errors++; $display("FAIL pos_latency got %0d want 0", cur_position); end
        step = 1'b0;
        tick();
        checks++; if (cur_position !== 19'h7FFFF) begin errors++; $display("FAIL pos_neg got %h want 7ffff", cur_position); end
        step_pulse(1'b1);
        checks++; if (cur_position !== 19'sd0) begin errors++; $display("FAIL pos_wrap got %h want 0", cur_position); end
    endtask

    task automatic test_closed_loop();
        int exp_s [2] = '{3, 2};
        int exp_d [2] = '{4, 6};
        logic exp_r [2] = '{1'b1, 1'b0};
        pos_clear = 1'b1;
        tick();
        pos_clear = 1'b0;
        drive_wr(1'b1, 4, 3);
        tick();
        drive_wr(1'b0, 6, 2);
        tick();
        wr_en = 1'b0;
        for (int s = 0; s < 2; s++) begin
            int t = 0;
            int n;
            int dv;
            logic r;
            while (!seg_valid && t < 20) begin
                tick();
                t++;
            end
            checks++; if (t >= 20) begin errors++; $display("FAIL loop_wait%0d got timeout want seg_valid", s); end
            n  = int'(stepsToGo);
            dv = int'(divider);
            r  = dirInput;
            checks++; if (n != exp_s[s] || dv != exp_d[s] || r !== exp_r[s]) begin errors++; $display("FAIL loop_seg%0d got %0d/%0d/%b want %0d/%0d/%b", s, n, dv, r, exp_s[s], exp_d[s], exp_r[s]); end
            seg_take = 1'b1;
            tick();
            seg_take = 1'b0;
            for (int i = 0; i < n && i < 16; i++) begin
                dir  = r;
                step = 1'b1;
                tick();
                step = 1'b0;
                for (int c = 1; c < dv && c < 16; c++) tick();
            end
            if (s == 0) begin
                checks++; if (cur_position !== 19'sd3) begin errors++; $display("FAIL loop_mid got %0d want 3", cur_position); end
            end
        end
        repeat (3) tick();
        checks++; if (cur_position !== 19'sd1) begin errors++; $display("FAIL loop_pos got %0d want 1", cur_position); end
        checks++; if (level !== 3'd0 || seg_valid !== 1'b0 || stepsToGo !== 15'd0) begin errors++; $display("FAIL loop_idle got lvl=%0d v=%b steps=%0d want 0 0 0", level, seg_valid, stepsToGo); end
    endtask

    initial begin
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_dir     = 1'b0;
        wr_divider = 15'd0;
        wr_steps   = 15'd0;
        flush      = 1'b0;
        seg_take   = 1'b0;
        step       = 1'b0;
        dir        = 1'b0;
        pos_clear  = 1'b0;
        test_reset();
        test_write_take();
        test_overflow_flush();
        test_full_push_pop();
        test_zero_and_empty();
        test_position();
        test_closed_loop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
